// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard request and hazard controller response bundle.
// The master drives the decode fields; the slave (the controller) returns stall/forward/busy.
interface hazard_scoreboard_if;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic       useRsD;
  logic       useRtD;
  logic [1:0] TuseRsD;
  logic [1:0] TuseRtD;
  logic [4:0] A3D;
  logic [1:0] TnewD;
  logic       mdUseD;
  logic       mdStartE;
  logic       stallF;
  logic       clrE;
  logic [1:0] fwdRsD;
  logic [1:0] fwdRtD;
  logic       mdBusy;

  modport master (
    output rsD, rtD, useRsD, useRtD, TuseRsD, TuseRtD, A3D, TnewD, mdUseD, mdStartE,
    input  stallF, clrE, fwdRsD, fwdRtD, mdBusy
  );

  modport slave (
    input  rsD, rtD, useRsD, useRtD, TuseRsD, TuseRtD, A3D, TnewD, mdUseD, mdStartE,
    output stallF, clrE, fwdRsD, fwdRtD, mdBusy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard controller for a 5-stage pipeline: E/M/W scoreboard of in-flight
// writes plus a mult/div busy counter, producing stall, bubble and forward selects.
module hazard_scoreboard #(
  parameter int unsigned MD_CYCLES = 5,
  parameter int unsigned CNT_W     = 4
) (
  input logic               clk,
  input logic               reset,
  hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } entry_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] fwd;
  } resolve_t;

  entry_t             e_q, m_q, w_q;
  entry_t             e_d, m_d, w_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  resolve_t           rs_res, rt_res;
  logic               md_stall;
  logic               stall;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Youngest matching stage wins; $0 never matches, so bubbles are invisible.
  function automatic resolve_t resolve(input logic rd, input logic [4:0] r,
                                       input logic [1:0] tuse,
                                       input entry_t e, input entry_t m, input entry_t w);
    resolve_t   res;
    entry_t     hit;
    logic [1:0] code;
    logic       found;
    res   = '0;
    hit   = '0;
    code  = 2'b00;
    found = 1'b0;
    if (rd && r != 5'd0) begin
      if (e.dst == r) begin
        hit = e; code = 2'b01; found = 1'b1;
      end else if (m.dst == r) begin
        hit = m; code = 2'b10; found = 1'b1;
      end else if (w.dst == r) begin
        hit = w; code = 2'b11; found = 1'b1;
      end
    end
    if (found) begin
      res.stall = (hit.tnew > tuse);
      res.fwd   = (hit.tnew == 2'd0) ? code : 2'b00;
    end
    return res;
  endfunction

  // NOTE: every signal driven here gets a value on all paths, so no latch is inferred.
  always_comb begin
    rs_res   = resolve(bus.useRsD, bus.rsD, bus.TuseRsD, e_q, m_q, w_q);
    rt_res   = resolve(bus.useRtD, bus.rtD, bus.TuseRtD, e_q, m_q, w_q);
    md_stall = bus.mdUseD & ((cnt_q != '0) | bus.mdStartE);
    stall    = rs_res.stall | rt_res.stall | md_stall;

    bus.stallF = stall;
    bus.clrE   = stall;
    bus.fwdRsD = stall ? 2'b00 : rs_res.fwd;
    bus.fwdRtD = stall ? 2'b00 : rt_res.fwd;
    bus.mdBusy = (cnt_q != '0);
  end

  always_comb begin
    w_d.dst  = m_q.dst;
    w_d.tnew = sat_dec(m_q.tnew);
    m_d.dst  = e_q.dst;
    m_d.tnew = sat_dec(e_q.tnew);
    if (stall) begin
      e_d = '0;
    end else begin
      e_d.dst  = bus.A3D;
      e_d.tnew = sat_dec(bus.TnewD);
    end

    // A restart reloads rather than accumulates.
    if (bus.mdStartE) begin
      cnt_d = CNT_W'(MD_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus randomized decode
// streams checked against an instruction-history model of the Tnew/Tuse rules.
module tb_hazard_scoreboard;
  localparam int MD_CYCLES = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_if bus();

  hazard_scoreboard #(.MD_CYCLES(MD_CYCLES), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Model: the decode instruction seen 1, 2, 3 cycles ago (age 1 = now in E).
  int h_dst  [1:3];
  int h_tnew [1:3];
  int cyc;
  int last_start;

  function automatic logic [6:0] obs();
    return {bus.stallF, bus.clrE, bus.fwdRsD, bus.fwdRtD, bus.mdBusy};
  endfunction

  function automatic void operand(input bit rd, input int r, input int tuse,
                                  output bit st, output int fwd);
    bit found;
    st = 0; fwd = 0; found = 0;
    if (rd && r != 0) begin
      for (int a = 1; a <= 3; a++) begin
        if (!found && h_dst[a] == r) begin
          int t;
          found = 1;
          t   = (h_tnew[a] > a) ? h_tnew[a] - a : 0;
          st  = (t > tuse);
          fwd = (t == 0) ? a : 0;
        end
      end
    end
  endfunction

  function automatic logic [6:0] model_expect(output bit st);
    bit srs, srt, busy;
    int frs, frt;
    operand(bus.useRsD, int'(bus.rsD), int'(bus.TuseRsD), srs, frs);
    operand(bus.useRtD, int'(bus.rtD), int'(bus.TuseRtD), srt, frt);
    busy = (cyc > last_start) && (cyc - last_start <= MD_CYCLES);
    st   = srs | srt | (bus.mdUseD & (busy | bus.mdStartE));
    if (st) begin frs = 0; frt = 0; end
    return {st, st, 2'(frs), 2'(frt), busy};
  endfunction

  task automatic model_reset();
    for (int a = 1; a <= 3; a++) begin h_dst[a] = 0; h_tnew[a] = 0; end
    cyc = 0;
    last_start = -100;
  endtask

  task automatic clear_inputs();
    bus.rsD = 0; bus.rtD = 0; bus.useRsD = 0; bus.useRtD = 0;
    bus.TuseRsD = 0; bus.TuseRtD = 0; bus.A3D = 0; bus.TnewD = 0;
    bus.mdUseD = 0; bus.mdStartE = 0;
  endtask

  // Advance one clock; inputs are stable across the edge, then return at the next negedge.
  task automatic cycle();
    bit st;
    logic [6:0] unused_e;
    unused_e = model_expect(st);
    @(posedge clk);
    h_dst[3] = h_dst[2]; h_tnew[3] = h_tnew[2];
    h_dst[2] = h_dst[1]; h_tnew[2] = h_tnew[1];
    h_dst[1] = st ? 0 : int'(bus.A3D);
    h_tnew[1] = st ? 0 : int'(bus.TnewD);
    if (bus.mdStartE) last_start = cyc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.rsD = 5'($urandom); bus.rtD = 5'($urandom); bus.useRsD = 0; bus.useRtD = 0;
    bus.A3D = 5'($urandom); bus.TnewD = 2'($urandom); bus.mdStartE = 1'($urandom);
    bus.mdUseD = 0;
    #1;
    checks++;
    if (obs() !== 7'b0000000) begin
      failures++; $display("FAIL reset_held obs=%b expected=%b", obs(), 7'b0000000);
    end
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    model_reset();
    bus.rsD = 5; bus.useRsD = 1;
    #1;
    checks++;
    if (obs() !== 7'b0000000) begin
      failures++; $display("FAIL reset_empty_board obs=%b expected=%b", obs(), 7'b0000000);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.A3D = 8; bus.TnewD = 3;
    #1;
    checks++;
    if (obs() !== 7'b0000000) begin
      failures++; $display("FAIL load_use_c0 obs=%b expected=%b", obs(), 7'b0000000);
    end
    cycle();
    clear_inputs();
    bus.rsD = 8; bus.useRsD = 1; bus.TuseRsD = 0;
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++;
      if (obs() !== 7'b1100000) begin
        failures++; $display("FAIL load_use_stall_c%0d obs=%b expected=%b", c, obs(), 7'b1100000);
      end
      cycle();
    end
    #1;
    checks++;
    if (obs() !== 7'b0011000) begin
      failures++; $display("FAIL load_use_fwd_w obs=%b expected=%b", obs(), 7'b0011000);
    end
    cycle();
  endtask

  task automatic test_alu_forward();
    do_reset();
    bus.A3D = 9; bus.TnewD = 1;
    cycle();
    clear_inputs();
    bus.rsD = 9; bus.useRsD = 1; bus.TuseRsD = 0;
    #1;
    checks++;
    if (obs() !== 7'b0001000) begin
      failures++; $display("FAIL alu_fwd_e obs=%b expected=%b", obs(), 7'b0001000);
    end
    cycle();
  endtask

  task automatic test_zero_priority();
    do_reset();
    bus.A3D = 0; bus.TnewD = 3;
    cycle();
    clear_inputs();
    bus.rsD = 0; bus.useRsD = 1;
    #1;
    checks++;
    if (obs() !== 7'b0000000) begin
      failures++; $display("FAIL zero_reg obs=%b expected=%b", obs(), 7'b0000000);
    end
    clear_inputs();
    bus.A3D = 4; bus.TnewD = 2;
    cycle();
    bus.A3D = 4; bus.TnewD = 1;
    cycle();
    clear_inputs();
    bus.rtD = 4; bus.useRtD = 1; bus.TuseRtD = 1;
    #1;
    checks++;
    if (obs() !== 7'b0000010) begin
      failures++; $display("FAIL priority_e_over_m obs=%b expected=%b", obs(), 7'b0000010);
    end
    cycle();
  endtask

  task automatic test_muldiv();
    do_reset();
    bus.mdUseD = 1; bus.mdStartE = 1;
    #1;
    checks++;
    if (obs() !== 7'b1100000) begin
      failures++; $display("FAIL md_c0 obs=%b expected=%b", obs(), 7'b1100000);
    end
    cycle();
    bus.mdStartE = 0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      checks++;
      if (obs() !== 7'b1100001) begin
        failures++; $display("FAIL md_busy_c%0d obs=%b expected=%b", c, obs(), 7'b1100001);
      end
      cycle();
    end
    #1;
    checks++;
    if (obs() !== 7'b0000000) begin
      failures++; $display("FAIL md_release_c6 obs=%b expected=%b", obs(), 7'b0000000);
    end
    cycle();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.A3D = 8; bus.TnewD = 3;
    cycle();
    clear_inputs();
    bus.rsD = 8; bus.useRsD = 1;
    #1;
    checks++;
    if (obs() !== 7'b1100000) begin
      failures++; $display("FAIL async_pre_stall obs=%b expected=%b", obs(), 7'b1100000);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (obs() !== 7'b0000000) begin
      failures++; $display("FAIL async_drop obs=%b expected=%b", obs(), 7'b0000000);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs() !== 7'b0000000) begin
      failures++; $display("FAIL async_released obs=%b expected=%b", obs(), 7'b0000000);
    end
    cycle();
    #1;
    checks++;
    if (obs() !== 7'b0000000) begin
      failures++; $display("FAIL async_board_empty obs=%b expected=%b", obs(), 7'b0000000);
    end
    cycle();
  endtask

  task automatic test_random();
    bit st;
    logic [6:0] exp_v;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.rsD      = 5'($urandom_range(0, 3));
      bus.rtD      = 5'($urandom_range(0, 3));
      bus.useRsD   = 1'($urandom);
      bus.useRtD   = 1'($urandom);
      bus.TuseRsD  = 2'($urandom);
      bus.TuseRtD  = 2'($urandom);
      bus.A3D      = 5'($urandom_range(0, 3));
      bus.TnewD    = 2'($urandom);
      bus.mdUseD   = ($urandom_range(0, 3) == 0);
      bus.mdStartE = ($urandom_range(0, 7) == 0);
      #1;
      exp_v = model_expect(st);
      checks++;
      if (obs() !== exp_v) begin
        failures++; $display("FAIL random_i%0d obs=%b expected=%b", i, obs(), exp_v);
      end
      cycle();
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset = 1'b0;
    test_reset();
    test_load_use();
    test_alu_forward();
    test_zero_priority();
    test_muldiv();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Hazard controller for the 5-stage pipeline. It produces the bubble (clrE) that drives the D/E pipeline register and the freeze signal for F/D.
- It keeps its own 3-entry scoreboard, one entry each for E, M and W. Each entry holds the destination register and a Tnew countdown for an in-flight write.
- Each cycle it compares the decode-stage operand needs (Tuse) against the scoreboard and emits a stall or forward selects.
- It also tracks a multi-cycle mult/div busy counter and stalls HI/LO consumers while the counter is running.

Parameters:
- MD_CYCLES, 5, cycles the mult/div unit stays busy after a start (1..15).
- CNT_W, 4, width of the busy counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rsD  in  5  rs field of the decode-stage instruction.
- rtD  in  5  rt field of the decode-stage instruction.
- useRsD  in  1  decode instruction reads rs.
- useRtD  in  1  decode instruction reads rt.
- TuseRsD  in  2  cycles until rs is needed (0 = needed in D).
- TuseRtD  in  2  cycles until rt is needed.
- A3D  in  5  destination register of the decode instruction (0 = none).
- TnewD  in  2  cycles until the decode result exists, as counted in D.
- mdUseD  in  1  decode instruction is a mult/div/mfhi/mflo/mthi/mtlo.
- mdStartE  in  1  mult/div issuing in E this cycle.
- stallF  out  1  hold PC and the F/D register.
- clrE  out  1  load a bubble into the D/E register.
- fwdRsD  out  2  rs forward select: 00 regfile, 01 E, 10 M, 11 W.
- fwdRtD  out  2  rt forward select, same encoding as fwdRsD.
- mdBusy  out  1  mult/div counter is non-zero.

Behaviour:
- State: entries E, M, W, each holding {dst[4:0], tnew[1:0]}, plus a busy counter cnt[CNT_W-1:0].
- Reset (reset=0, asynchronous): all dst=0, all tnew=0, cnt=0.
  - Resulting outputs: stallF=0, clrE=0, fwd=00, mdBusy=0, provided useRs/useRt are low.
- Scoreboard shift, every rising edge:
  - W <= {M.dst, sat(M.tnew-1)}.
  - M <= {E.dst, sat(E.tnew-1)}.
  - E <= stall ? {0, 0} : {A3D, sat(TnewD-1)}.
  - sat(x-1) means 0 when x=0, otherwise x-1. This is the same rule the D/E register applies to Tnew.
- Operand match (shown for rs; rt is identical):
  - Matching requires useRsD=1, rsD!=0, and stage dst==rsD.
  - Priority is E > M > W; only the youngest matching stage is considered.
- stallRs = youngest match exists and its tnew > TuseRsD.
- fwdRsD:
  - Youngest match with tnew==0: stage code (E=01, M=10, W=11).
  - Otherwise 00.
  - fwdRsD is don't-care (forced 00) while stall=1.
  - Register $0 is never forwarded, even if a bubble dst=0 matches.
- mdStall = mdUseD & (cnt!=0 | mdStartE).
- stall = stallRs | stallRt | mdStall.
- stallF = stall and clrE = stall, both combinational from current state and inputs, valid in the same cycle.
- Busy counter:
  - mdStartE=1 loads cnt=MD_CYCLES. A restart while busy reloads the counter; it does not add.
  - Otherwise, if cnt!=0, cnt decrements.
  - mdBusy = (cnt!=0).
- Simultaneous events:
  - Register and md stall in the same cycle produce one stall cycle (OR).
  - A stalled decode instruction re-evaluates next cycle against the shifted scoreboard. No other latching is required.
- Reset asserted mid-stall clears the scoreboard at once. stallF drops combinationally unless the current D inputs themselves conflict with the empty board, which is impossible: every match requires a dst equal to a non-zero rs.

Test Plan:
- Reset: reset=0 with arbitrary D inputs, then release → stallF=0, mdBusy=0. Scoreboard empty: rsD=5, useRsD=1 gives fwdRsD=00.
- Load-use: cycle 0 D has A3D=8, TnewD=3 (lw). Cycle 1 D has rsD=8, TuseRsD=0 → E.tnew=2, so stallF=clrE=1 in cycles 1 and 2. Cycle 3: entry in W with tnew=0 → fwdRsD=11, stall=0.
- ALU forward: A3D=9, TnewD=1. Next cycle rsD=9, TuseRsD=0 → E.tnew=0, fwdRsD=01, no stall.
- $0 and priority: A3D=0 followed by rsD=0 → no stall, fwd=00. A3D=4 twice, then rtD=4 with TuseRtD=1 → E entry governs (fwdRtD=01), not M.
- Mult/div: mdStartE=1 at cycle 0 with MD_CYCLES=5, mdUseD=1 held → stall cycles 0–5. Stall releases at cycle 6 when cnt=0, and mdBusy falls in the same cycle.
- Async reset mid-stall: during load-use stall, drive reset=0 between clock edges → stallF/clrE drop immediately with no clock edge, and the scoreboard stays empty after release.
